// File: rtl/console_pkg.sv
// Shared types and constants for the character-cell text console.
package console_pkg;

  typedef enum logic [1:0] {
    CLEAR    = 2'd0,
    IDLE     = 2'd1,
    CLR_LINE = 2'd2
  } state_e;

  localparam int CHAR_W = 8;
  localparam int CHAR_H = 16;

  localparam logic [7:0] CR_CODE = 8'h0D;
  localparam logic [7:0] LF_CODE = 8'h0A;
  localparam logic [7:0] BS_CODE = 8'h08;

endpackage

// File: rtl/text_buffer_ram.sv
// Screen character buffer: one write port, one registered read-first read port.
module text_buffer_ram #(
  parameter int DEPTH  = 3600,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  // Read and write share one block so a same-address collision returns old data.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/text_console_ctrl.sv
// Text console: byte stream in, cursor/control-code handling, screen clears,
// and a registered cell lookup for the glyph path.
//
// state    | meaning
// CLEAR    | blanking the whole screen, one cell per cycle
// IDLE     | accepting bytes from the stream
// CLR_LINE | blanking the row the cursor just advanced onto
module text_console_ctrl
  import console_pkg::*;
#(
  parameter int         COLS             = 80,
  parameter int         ROWS             = 45,
  parameter int         HORIZONTAL_WIDTH = 1650,
  parameter int         VERTICAL_WIDTH   = 750,
  parameter logic [7:0] BLANK_CHAR       = 8'h20
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic [7:0]                          i_char,
  input  logic                                i_char_valid,
  output logic                                o_char_ready,
  input  logic                                i_clear,
  input  logic [$clog2(HORIZONTAL_WIDTH)-1:0] i_sx,
  input  logic [$clog2(VERTICAL_WIDTH)-1:0]   i_sy,
  output logic [7:0]                          o_glyph_char,
  output logic                                o_glyph_en,
  output logic [$clog2(COLS)-1:0]             o_cursor_col,
  output logic [$clog2(ROWS)-1:0]             o_cursor_row,
  output logic                                o_busy
);

  localparam int CELLS  = COLS * ROWS;
  localparam int ADDR_W = $clog2(CELLS);
  localparam int SX_W   = $clog2(HORIZONTAL_WIDTH);
  localparam int SY_W   = $clog2(VERTICAL_WIDTH);
  localparam int COL_W  = $clog2(COLS);
  localparam int ROW_W  = $clog2(ROWS);

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic              glyph_en_q;

  logic [ROW_W-1:0]  next_row;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] cur_addr;
  logic              accept;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              lk_in_area;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;

  assign o_char_ready = (state_q == IDLE) && !i_clear;
  assign accept       = o_char_ready && i_char_valid;
  assign o_busy       = (state_q != IDLE);
  assign o_cursor_col = col_q;
  assign o_cursor_row = row_q;

  assign next_row = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + 1'b1;
  assign row_base = ADDR_W'(row_q) * ADDR_W'(COLS);
  assign cur_addr = row_base + ADDR_W'(col_q);

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = cnt_q;
    wr_data = BLANK_CHAR;
    case (state_q)
      CLEAR: wr_en = 1'b1;
      CLR_LINE: begin
        wr_en   = 1'b1;
        wr_addr = row_base + cnt_q;
      end
      IDLE: begin
        if (accept) begin
          if (i_char == BS_CODE) begin
            wr_en   = (col_q != '0);
            wr_addr = cur_addr - 1'b1;
          end else if (i_char != CR_CODE && i_char != LF_CODE) begin
            wr_en   = 1'b1;
            wr_addr = cur_addr;
            wr_data = i_char;
          end
        end
      end
      default: wr_en = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      col_q      <= '0;
      row_q      <= '0;
      glyph_en_q <= 1'b0;
    end else begin
      glyph_en_q <= lk_in_area;
      case (state_q)
        CLEAR: begin
          if (cnt_q == ADDR_W'(CELLS - 1)) begin
            cnt_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        IDLE: begin
          if (i_clear) begin
            cnt_q   <= '0;
            state_q <= CLEAR;
          end else if (i_char_valid) begin
            case (i_char)
              CR_CODE: col_q <= '0;
              LF_CODE: begin
                col_q   <= '0;
                row_q   <= next_row;
                cnt_q   <= '0;
                state_q <= CLR_LINE;
              end
              BS_CODE: if (col_q != '0) col_q <= col_q - 1'b1;
              default: begin
                if (col_q == COL_W'(COLS - 1)) begin
                  col_q   <= '0;
                  row_q   <= next_row;
                  cnt_q   <= '0;
                  state_q <= CLR_LINE;
                end else begin
                  col_q <= col_q + 1'b1;
                end
              end
            endcase
          end
        end
        CLR_LINE: begin
          if (cnt_q == ADDR_W'(COLS - 1)) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  // Off-screen positions read address 0 so the RAM is never indexed out of range.
  assign lk_in_area = (i_sx < SX_W'(COLS * CHAR_W)) && (i_sy < SY_W'(ROWS * CHAR_H));
  assign rd_addr    = lk_in_area ?
                      ADDR_W'(i_sy >> $clog2(CHAR_H)) * ADDR_W'(COLS) + ADDR_W'(i_sx >> $clog2(CHAR_W)) :
                      '0;

  text_buffer_ram #(
    .DEPTH (CELLS),
    .ADDR_W(ADDR_W)
  ) u_buf (
    .clk_i  (i_clk),
    .we_i   (wr_en),
    .waddr_i(wr_addr),
    .wdata_i(wr_data),
    .raddr_i(rd_addr),
    .rdata_o(rd_data)
  );

  assign o_glyph_char = glyph_en_q ? rd_data : 8'h00;
  assign o_glyph_en   = glyph_en_q;

endmodule

// File: tb/tb_text_console_ctrl.sv
// Directed bench for text_console_ctrl: clears, cursor moves, control codes, lookups.
module tb_text_console_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  i_char = 8'h00;
  logic        i_char_valid = 1'b0;
  logic        o_char_ready;
  logic        i_clear = 1'b0;
  logic [10:0] i_sx = '0;
  logic [9:0]  i_sy = '0;
  logic [7:0]  o_glyph_char;
  logic        o_glyph_en;
  logic [6:0]  o_cursor_col;
  logic [5:0]  o_cursor_row;
  logic        o_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  text_console_ctrl dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_char      (i_char),
    .i_char_valid(i_char_valid),
    .o_char_ready(o_char_ready),
    .i_clear     (i_clear),
    .i_sx        (i_sx),
    .i_sy        (i_sy),
    .o_glyph_char(o_glyph_char),
    .o_glyph_en  (o_glyph_en),
    .o_cursor_col(o_cursor_col),
    .o_cursor_row(o_cursor_row),
    .o_busy      (o_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] c, output int waited);
    waited = 0;
    i_char = c;
    i_char_valid = 1'b1;
    while (!o_char_ready && waited < 10000) begin
      @(negedge clk);
      waited++;
    end
    chk("send_timeout", waited < 10000, 1);
    @(negedge clk);
    i_char_valid = 1'b0;
  endtask

  task automatic count_busy(output int n, output int ready_seen);
    n = 0;
    ready_seen = 0;
    while (o_busy && n < 5000) begin
      n++;
      if (o_char_ready) ready_seen++;
      @(negedge clk);
    end
  endtask

  task automatic look(input int sx, input int sy, output logic [7:0] ch, output logic en);
    i_sx = 11'(sx);
    i_sy = 10'(sy);
    @(negedge clk);
    ch = o_glyph_char;
    en = o_glyph_en;
  endtask

  task automatic chk_cell(input string tag, input int col, input int row, input logic [7:0] exp);
    logic [7:0] ch;
    logic en;
    look(col * 8 + (col % 8), row * 16 + (col % 16), ch, en);
    chk({tag, "_en"}, en, 1);
    chk(tag, ch, exp);
  endtask

  initial begin
    int n, rs, w;
    logic [7:0] ch;
    logic en;

    // Reset held: outputs at their reset values.
    repeat (3) @(negedge clk);
    chk("rst_busy", o_busy, 1);
    chk("rst_ready", o_char_ready, 0);
    chk("rst_glyph_en", o_glyph_en, 0);
    chk("rst_glyph_char", o_glyph_char, 0);
    chk("rst_col", o_cursor_col, 0);
    chk("rst_row", o_cursor_row, 0);

    rst_n = 1'b1;
    count_busy(n, rs);
    chk("init_clear_cycles", n, 3600);
    chk("init_clear_ready", rs, 0);
    chk("init_col", o_cursor_col, 0);
    chk("init_row", o_cursor_row, 0);
    chk_cell("blank_0_0", 0, 0, 8'h20);
    chk_cell("blank_79_44", 79, 44, 8'h20);
    chk_cell("blank_12_18", 12, 18, 8'h20);
    look(639, 719, ch, en);
    chk("corner_en", en, 1);
    chk("corner_char", ch, 8'h20);
    look(640, 100, ch, en);
    chk("sx640_en", en, 0);
    look(100, 720, ch, en);
    chk("sy720_en", en, 0);

    // Single printable byte.
    send(8'h41, w);
    chk("A_latency", w, 0);
    chk("A_col", o_cursor_col, 1);
    chk("A_row", o_cursor_row, 0);
    chk("A_busy", o_busy, 0);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 8; x++) begin
        look(x, y, ch, en);
        chk("A_pixel", ch, 8'h41);
      end

    // CR then a full row of '0' wraps to row 1.
    send(8'h0D, w);
    chk("cr_col", o_cursor_col, 0);
    for (int i = 0; i < 80; i++) send(8'h30, w);
    chk("wrap_col", o_cursor_col, 0);
    chk("wrap_row", o_cursor_row, 1);
    count_busy(n, rs);
    chk("wrap_clr_cycles", n, 80);
    for (int c = 0; c < 80; c++) chk_cell("row0_fill", c, 0, 8'h30);
    chk_cell("row1_blank", 5, 1, 8'h20);

    // Backspace at column 0 is a no-op; "AB"+BS blanks the B.
    send(8'h08, w);
    chk("bs0_col", o_cursor_col, 0);
    chk("bs0_row", o_cursor_row, 1);
    chk("bs0_busy", o_busy, 0);
    chk_cell("bs0_cell", 0, 1, 8'h20);
    send(8'h41, w);
    send(8'h42, w);
    chk_cell("B_written", 1, 1, 8'h42);
    send(8'h08, w);
    chk("bs_col", o_cursor_col, 1);
    chk("bs_row", o_cursor_row, 1);
    chk_cell("bs_blank", 1, 1, 8'h20);
    chk_cell("bs_keep", 0, 1, 8'h41);

    // Line feeds down to the last row.
    for (int i = 0; i < 43; i++) send(8'h0A, w);
    count_busy(n, rs);
    chk("lf44_col", o_cursor_col, 0);
    chk("lf44_row", o_cursor_row, 44);
    chk_cell("lf_row1_kept", 0, 1, 8'h41);
    chk_cell("lf_row0_kept", 7, 0, 8'h30);

    // Wrap to row 0; a clear pulse during CLR_LINE is dropped.
    send(8'h0A, w);
    chk("lfwrap_col", o_cursor_col, 0);
    chk("lfwrap_row", o_cursor_row, 0);
    i_clear = 1'b1;
    n = 1;
    rs = 0;
    @(negedge clk);
    i_clear = 1'b0;
    while (o_busy && n < 5000) begin
      n++;
      @(negedge clk);
    end
    chk("lfwrap_clr_cycles", n, 80);
    chk_cell("row0_blank_a", 0, 0, 8'h20);
    chk_cell("row0_blank_b", 40, 0, 8'h20);
    chk_cell("row0_blank_c", 79, 0, 8'h20);
    chk_cell("row1_after_wrap", 0, 1, 8'h41);

    // Clear and valid together: byte held off until the clear completes.
    send(8'h51, w);
    chk("Q_col", o_cursor_col, 1);
    i_char = 8'h5A;
    i_char_valid = 1'b1;
    i_clear = 1'b1;
    #1;
    chk("clr_ready_low", o_char_ready, 0);
    @(negedge clk);
    i_clear = 1'b0;
    count_busy(n, rs);
    chk("clr_cycles", n, 3600);
    chk("clr_ready_seen", rs, 0);
    chk("clr_col", o_cursor_col, 0);
    chk("clr_row", o_cursor_row, 0);
    chk("clr_ready_after", o_char_ready, 1);
    @(negedge clk);
    i_char_valid = 1'b0;
    chk("Z_col", o_cursor_col, 1);
    chk("Z_row", o_cursor_row, 0);
    chk_cell("Z_cell", 0, 0, 8'h5A);
    chk_cell("clr_row1", 0, 1, 8'h20);

    // Reset in the middle of a line clear reruns the full clear.
    send(8'h0A, w);
    chk("mid_row", o_cursor_row, 1);
    repeat (10) @(negedge clk);
    chk("mid_busy", o_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_col", o_cursor_col, 0);
    chk("mid_rst_row", o_cursor_row, 0);
    chk("mid_rst_busy", o_busy, 1);
    @(negedge clk);
    rst_n = 1'b1;
    count_busy(n, rs);
    chk("mid_rst_clear_cycles", n, 3600);
    chk_cell("mid_rst_cell0", 0, 0, 8'h20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
